// File: rtl/mul_div_controller_pkg.sv
// rtl/mul_div_controller_pkg.sv - shared types and constants for the multiply/divide unit
package mdu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_WAIT,
    DIV_RUN,
    DIV_FIX,
    DONE
  } mdu_state_t;

  localparam logic OP_MUL    = 1'b0;
  localparam logic OP_DIV    = 1'b1;
  localparam int   DIV_ITERS = 32;

  // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mul_div_controller_if.sv
// rtl/mul_div_controller_if.sv - request/result bus of the multiply/divide unit
interface mul_div_controller_if;

  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational iteration of restoring division
module div_restore_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // rem_i < dvs_i <= 2^31 always holds, so shifted never exceeds 32 bits and diff[32] is the sign.
  always_comb begin
    shifted = {rem_i, quo_i[31]};
    diff    = shifted - {1'b0, dvs_i};
    if (!diff[32]) begin
      rem_o = diff[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/multiplier_32b.sv
// rtl/multiplier_32b.sv - combinational 32x32 signed multiplier, 64-bit product
module multiplier_32b (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] p_o
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;

  // Sign-extend first so the low 64 bits of the product are the signed result.
  assign a_ext = {{32{a_i[31]}}, a_i};
  assign b_ext = {{32{b_i[31]}}, b_i};
  assign p_o   = a_ext * b_ext;

endmodule

// File: rtl/mul_div_controller.sv
// rtl/mul_div_controller.sv - start/busy/done sequencer for MUL settle window and restoring DIV
module mul_div_controller
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mul_div_controller_if.slave  bus
);

  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);
  localparam logic [4:0] ITER_LAST = 5'(DIV_ITERS - 1);

  mdu_state_t  state_q;
  logic [31:0] a_q, b_q;
  logic [3:0]  cnt_q;
  logic [4:0]  iter_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        neg_quo_q, neg_rem_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q, done_q, dbz_q;

  logic [63:0] prod;
  logic [31:0] rem_d, quo_d;

  // Product is only sampled at the end of MUL_WAIT: a multicycle path from a_q/b_q.
  multiplier_32b u_mul (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod)
  );

  div_restore_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      iter_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (bus.start) begin
            a_q <= bus.a;
            b_q <= bus.b;
            if (bus.op == OP_MUL) begin
              state_q <= MUL_WAIT;
              cnt_q   <= MUL_LOAD;
              busy_q  <= 1'b1;
            end else if (bus.b == '0) begin
              state_q <= DONE;
              lo_q    <= '1;
              hi_q    <= bus.a;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q   <= DIV_RUN;
              iter_q    <= '0;
              rem_q     <= '0;
              quo_q     <= abs32(bus.a);
              dvs_q     <= abs32(bus.b);
              neg_quo_q <= bus.a[31] ^ bus.b[31];
              neg_rem_q <= bus.a[31];
              busy_q    <= 1'b1;
            end
          end
        end
        MUL_WAIT: begin
          if (cnt_q == 4'd0) begin
            hi_q    <= prod[63:32];
            lo_q    <= prod[31:0];
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DIV_RUN: begin
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          iter_q <= iter_q + 5'd1;
          if (iter_q == ITER_LAST) begin
            state_q <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          // Truncating division: remainder takes the sign of the dividend.
          lo_q    <= neg_quo_q ? (~quo_q + 32'd1) : quo_q;
          hi_q    <= neg_rem_q ? (~rem_q + 32'd1) : rem_q;
          dbz_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_controller.sv
// tb/tb_mul_div_controller.sv - directed self-checking bench for mul_div_controller
module tb_mul_div_controller;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  int   busy_low;
  int   pulses;

  mul_div_controller_if bus ();

  mul_div_controller #(.MUL_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle k+1.
  task automatic go(input logic o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = OP_DIV;
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'h0;
  endtask

  task automatic wait_done(input int lat0, output int l, output int bl);
    l  = lat0;
    bl = 0;
    while (!bus.done && l < 200) begin
      if (!bus.busy) bl++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y,
                     input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                     input logic exp_dbz);
    int l, bl;
    go(o, x, y);
    wait_done(1, l, bl);
    check({tag, "_lat"}, 32'(l), 32'(exp_lat));
    check({tag, "_busy_low"}, 32'(bl), 32'd0);
    check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_hi"}, bus.hi, exp_hi);
    check({tag, "_lo"}, bus.lo, exp_lo);
    check({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, exp_dbz});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 32'd5;
    bus.b     = 32'd5;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    run("mul_neg", OP_MUL, 32'hFFFFFFF1, 32'd10, 3, 32'hFFFFFFFF, 32'hFFFFFF6A, 1'b0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("hold_lo", bus.lo, 32'hFFFFFF6A);

    run("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("div_100_m7", OP_DIV, 32'd100, 32'hFFFFFFF9, 34, 32'd2, 32'hFFFFFFF2, 1'b0);
    run("div_zero", OP_DIV, 32'h00001234, 32'd0, 1, 32'h00001234, 32'hFFFFFFFF, 1'b1);
    run("mul_3x3", OP_MUL, 32'd3, 32'd3, 3, 32'd0, 32'd9, 1'b0);
    run("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34, 32'd0, 32'h80000000, 1'b0);
    run("mul_min", OP_MUL, 32'h80000000, 32'h80000000, 3, 32'h40000000, 32'd0, 1'b0);

    // start during busy must be ignored
    @(negedge clk);
    go(OP_DIV, 32'd100, 32'hFFFFFFF9);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 32'd2;
    bus.b     = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(6, lat, busy_low);
    check("ign_lat", 32'(lat), 32'd34);
    check("ign_busy_low", 32'(busy_low), 32'd0);
    check("ign_hi", bus.hi, 32'd2);
    check("ign_lo", bus.lo, 32'hFFFFFFF2);

    // accepted in the DONE cycle
    go(OP_MUL, 32'd5, 32'hFFFFFFFD);
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(1, lat, busy_low);
    check("b2b_lat", 32'(lat), 32'd3);
    check("b2b_hi", bus.hi, 32'hFFFFFFFF);
    check("b2b_lo", bus.lo, 32'hFFFFFFF1);

    // reset in cycle k+10 of a DIV
    @(negedge clk);
    go(OP_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_lo_hold", bus.lo, 32'd0);

    run("mul_7x6", OP_MUL, 32'd7, 32'd6, 3, 32'd0, 32'd42, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_controller.md
# mul_div_controller

Sequencing controller for the CPU's multiply/divide unit. It accepts one MUL or DIV request through a start/busy/done handshake and latches the operands. A MUL gives the combinational `multiplier_32b` a fixed multicycle settle window; a DIV runs a 32-iteration restoring division on operand magnitudes. Results are written into the architectural HI/LO registers that feed the datapath bus.

## Interface
Parameters:
- `MUL_CYCLES`, default 2: cycles allowed for the combinational multiplier to settle. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request strobe, sampled only when the unit can accept.
- `op`  in  1  0 = MUL, 1 = DIV (`OP_MUL`/`OP_DIV`).
- `a`  in  32  signed operand: multiplicand / dividend.
- `b`  in  32  signed operand: multiplier / divisor.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO are updated.
- `hi`  out  32  MUL: upper product word. DIV: remainder.
- `lo`  out  32  MUL: lower product word. DIV: quotient.
- `div_by_zero`  out  1  set on completion of a DIV with b == 0; cleared on completion of any other operation.

## Operation
- States: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE.
- Accepting a request:
  - A request is accepted when `start`=1 and the state is IDLE or DONE.
  - `a`, `b` and `op` are latched into internal registers. Inputs may change after acceptance.
- MUL:
  - IDLE/DONE → MUL_WAIT. A down-counter is loaded with MUL_CYCLES-1.
  - On the edge where the counter reaches 0, `{hi,lo}` ← 64-bit signed product of the latched operands, then the FSM moves to DONE.
- DIV with b ≠ 0:
  - On acceptance: sign flags are stored, a 32-bit remainder register is cleared, and the quotient shift register is loaded with |a|.
  - DIV_RUN runs exactly 32 iterations, one per cycle:
    - shift {rem,quo} left by 1;
    - trial-subtract |b| from rem (33-bit);
    - if the result is non-negative, commit it and set quo[0]=1.
  - DIV_FIX (1 cycle):
    - quotient is negated iff sign(a)≠sign(b);
    - remainder is negated iff a<0 (truncation toward zero);
    - results are written to lo/hi; the FSM moves to DONE.
  - Magnitudes are taken as 32-bit unsigned, so |0x80000000| = 0x80000000.
  - The overflow case 0x80000000 / -1 yields lo=0x80000000, hi=0 with no special handling.
- DIV with b == 0:
  - Goes directly to DONE from acceptance.
  - lo ← 0xFFFFFFFF, hi ← a, `div_by_zero` ← 1.
- DONE:
  - Lasts one cycle; `done`=1 and `busy`=0.
  - Moves to IDLE, or to the new operation if `start`=1.
- HI/LO hold their value between completions. They change only on the completing edge.

## Timing
- Request accepted at edge k. `busy`=1 from cycle k+1 until the cycle before `done`.
- MUL: `done`=1 in cycle k+MUL_CYCLES+1. With the default, that is k+3.
- DIV (b≠0): DIV_RUN covers cycles k+1..k+32, DIV_FIX is k+33, `done`=1 in cycle k+34.
- DIV (b=0): `done`=1 in cycle k+1.
- `start` while `busy`=1 is ignored, with no queuing and no error.
- `start` in the DONE cycle is accepted. Back-to-back throughput is one operation per latency with no idle gap.
- Reset values: state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0; counters cleared.
- Reset mid-operation aborts the operation. No HI/LO write and no `done` pulse occur. Reset overrides a simultaneous `start`.

## Structure
- Package `mdu_pkg`:
  - state enum typedef `mdu_state_t`;
  - constants `OP_MUL`=1'b0, `OP_DIV`=1'b1;
  - `DIV_ITERS`=32.
- Instantiates the existing `multiplier_32b` on the latched operand registers. Its output is captured only at the end of MUL_WAIT, which makes it a declared multicycle path.
- New sub-module `div_restore_step`: combinational single iteration (rem, quo, divisor → rem', quo'). The controller registers its outputs each DIV_RUN cycle.

## Test plan
- MUL a=-15, b=10, start at k → `done` at k+3; hi=0xFFFFFFFF, lo=0xFFFFFF6A; `busy` high during k+1..k+2.
- DIV a=-7, b=2 → `done` at k+34; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=100, b=-7 → lo=0xFFFFFFF2, hi=2.
- DIV a=0x00001234, b=0 → `done` at k+1; lo=0xFFFFFFFF, hi=0x00001234, `div_by_zero`=1. A following MUL 3×3 clears it (lo=9, hi=0).
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. MUL 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- Start a DIV, pulse `start` with MUL at cycle k+5 → ignored; DIV result unaffected. Assert `start` with MUL in the DONE cycle → accepted, `done` 3 cycles later.
- Assert `reset` at cycle k+10 of a DIV → next cycle `busy`=0, hi=lo=0, no `done` pulse ever. A new MUL 7×6 then completes normally with lo=42.
